// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, per-opcode execute T3-T7, HALT.
// Optional memory handshake (mem_rdy) is enabled by defining CU_MEM_WAIT_EN.
module control_sequencer #(
   parameter logic [4:0] ADD_OP = 5'b00011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
`ifdef CU_MEM_WAIT_EN
   input  logic        mem_rdy,
`endif
   output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
   output logic        OutPort_in, IncPC, CON_in,
   output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
   output logic        InPort_out, C_out, BAout,
   output logic        Read, Write,
   output logic        Gra, Grb, Grc, Rin, Rout,
   output logic [15:0] RX_in_man,
   output logic [4:0]  alu_instruction_bits,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD = 5'd0,  OP_LDI = 5'd1,  OP_ST = 5'd2,
                          OP_ADD = 5'd3, OP_SHL = 5'd11, OP_ADDI = 5'd12,
                          OP_ORI = 5'd14, OP_MUL = 5'd15, OP_DIV = 5'd16,
                          OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19,
                          OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22,
                          OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25,
                          OP_HALT = 5'd27;

   state_t     state_q, state_d;
   logic [4:0] op;
   logic       is_alu, is_imm, is_un, is_md, is_mem;
   logic [3:0] last_st;
   logic       hold;
   logic       unused_ir;

   assign op        = IR_Data[31:27];
   assign unused_ir = ^IR_Data[26:0];
   assign is_alu    = (op >= OP_ADD)  && (op <= OP_SHL);
   assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
   assign is_un     = (op == OP_NEG)  || (op == OP_NOT);
   assign is_md     = (op == OP_MUL)  || (op == OP_DIV);
   assign is_mem    = (op == OP_LD)   || (op == OP_LDI) || (op == OP_ST);

`ifdef CU_MEM_WAIT_EN
   assign hold = !mem_rdy && ((state_q == S_T1) ||
                 (state_q == S_T6 && op == OP_LD) || (state_q == S_T7 && op == OP_ST));
`else
   assign hold = 1'b0;
`endif

   // Final execute state of each instruction; everything not listed ends at T3.
   always_comb begin
      last_st = S_T3;
      if (is_alu || is_imm || op == OP_LDI)  last_st = S_T5;
      else if (is_un || op == OP_JAL)        last_st = S_T4;
      else if (is_md || op == OP_BR)         last_st = S_T6;
      else if (op == OP_LD || op == OP_ST)   last_st = S_T7;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= S_RST;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (!hold) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (hold)                                  state_d = state_q;
            else if (state_q == S_T3 && op == OP_HALT) state_d = S_HALT;
            else if (state_q == last_st)               state_d = S_T0;
            else                                       state_d = state_t'(state_q + 4'd1);
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_comb begin
      {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in} = '0;
      {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, BAout} = '0;
      {Read, Write, Gra, Grb, Grc, Rin, Rout} = '0;
      RX_in_man            = '0;
      alu_instruction_bits = '0;
      run                  = (state_q != S_RST) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
         S_T1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
         S_T2: begin MDR_out = 1'b1; IR_in = 1'b1; end
         S_T3: begin
            if (is_alu || is_imm)   begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
            else if (is_un)         begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = op; end
            else if (is_md)         begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
            else if (is_mem)        begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
            else if (op == OP_BR)   begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
            else if (op == OP_JR)   begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
            else if (op == OP_JAL)  begin PC_out = 1'b1; RX_in_man = 16'h8000; end
            else if (op == OP_IN)   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (op == OP_OUT)  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
            else if (op == OP_MFHI) begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (op == OP_MFLO) begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         S_T4: begin
            if (is_alu)            begin Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = op; end
            else if (is_imm)       begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = op; end
            else if (is_un)        begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_md)        begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = op; end
            else if (is_mem)       begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ADD_OP; end
            else if (op == OP_BR)  begin PC_out = 1'b1; Y_in = 1'b1; end
            else if (op == OP_JAL) begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
         end
         S_T5: begin
            if (is_alu || is_imm || op == OP_LDI)  begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (is_md)                        begin Zlow_out = 1'b1; LO_in = 1'b1; end
            else if (op == OP_LD || op == OP_ST)   begin Zlow_out = 1'b1; MAR_in = 1'b1; end
            else if (op == OP_BR)                  begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ADD_OP; end
         end
         S_T6: begin
            if (is_md)             begin Zhigh_out = 1'b1; HI_in = 1'b1; end
            else if (op == OP_LD)  begin Read = 1'b1; MDR_in = 1'b1; end
            else if (op == OP_ST)  begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
            else if (op == OP_BR)  begin Zlow_out = 1'b1; PC_in = CON_out; end
         end
         S_T7: begin
            if (op == OP_LD)       begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (op == OP_ST)  Write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control words are queued per
// instruction and compared each cycle on the falling edge.
module tb_control_sequencer;

   typedef struct packed {
      logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in;
      logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, BAout;
      logic Read, Write, Gra, Grb, Grc, Rin, Rout;
      logic [15:0] rx;
      logic [4:0]  alu;
      logic        run;
   } cw_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        CON_out = 1'b0;
   logic        mem_rdy = 1'b1;
   logic [31:0] ir_q = '0;
   logic [31:0] next_instr = '0;
   logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in;
   logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, BAout;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, run;
   logic [15:0] RX_in_man;
   logic [4:0]  alu_instruction_bits;
   cw_t         act;
   cw_t         sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clr(clr), .IR_Data(ir_q), .CON_out(CON_out),
`ifdef CU_MEM_WAIT_EN
      .mem_rdy(mem_rdy),
`endif
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC), .CON_in(CON_in),
      .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out),
      .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out), .BAout(BAout),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .RX_in_man(RX_in_man), .alu_instruction_bits(alu_instruction_bits), .run(run)
   );

   assign act = {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in,
                 PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, BAout,
                 Read, Write, Gra, Grb, Grc, Rin, Rout, RX_in_man, alu_instruction_bits, run};

   // Minimal datapath: the IR loads the fetched word when the sequencer asks for it.
   always @(posedge clk) if (IR_in) ir_q <= next_instr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic cw_t nw();
      cw_t c = '0;
      c.run = 1'b1;
      return c;
   endfunction

   task automatic push_seq(input logic [4:0] op, input logic con);
      cw_t c;
      c = nw(); c.PC_out = 1; c.MAR_in = 1; c.IncPC = 1; c.Z_in = 1; sb.push_back(c);
      c = nw(); c.Zlow_out = 1; c.PC_in = 1; c.Read = 1; c.MDR_in = 1; sb.push_back(c);
      c = nw(); c.MDR_out = 1; c.IR_in = 1; sb.push_back(c);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
            c = nw(); c.Grb = 1; c.Rout = 1; c.Y_in = 1; sb.push_back(c);
            c = nw(); c.Grc = 1; c.Rout = 1; c.Z_in = 1; c.alu = op; sb.push_back(c);
            c = nw(); c.Zlow_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c);
         end
         5'd12, 5'd13, 5'd14: begin
            c = nw(); c.Grb = 1; c.Rout = 1; c.Y_in = 1; sb.push_back(c);
            c = nw(); c.C_out = 1; c.Z_in = 1; c.alu = op; sb.push_back(c);
            c = nw(); c.Zlow_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c);
         end
         5'd17, 5'd18: begin
            c = nw(); c.Grb = 1; c.Rout = 1; c.Z_in = 1; c.alu = op; sb.push_back(c);
            c = nw(); c.Zlow_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c);
         end
         5'd15, 5'd16: begin
            c = nw(); c.Gra = 1; c.Rout = 1; c.Y_in = 1; sb.push_back(c);
            c = nw(); c.Grb = 1; c.Rout = 1; c.Z_in = 1; c.alu = op; sb.push_back(c);
            c = nw(); c.Zlow_out = 1; c.LO_in = 1; sb.push_back(c);
            c = nw(); c.Zhigh_out = 1; c.HI_in = 1; sb.push_back(c);
         end
         5'd0, 5'd1, 5'd2: begin
            c = nw(); c.Grb = 1; c.BAout = 1; c.Y_in = 1; sb.push_back(c);
            c = nw(); c.C_out = 1; c.Z_in = 1; c.alu = 5'b00011; sb.push_back(c);
            if (op == 5'd1) begin
               c = nw(); c.Zlow_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c);
            end else begin
               c = nw(); c.Zlow_out = 1; c.MAR_in = 1; sb.push_back(c);
               if (op == 5'd0) begin
                  c = nw(); c.Read = 1; c.MDR_in = 1; sb.push_back(c);
                  c = nw(); c.MDR_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c);
               end else begin
                  c = nw(); c.Gra = 1; c.Rout = 1; c.MDR_in = 1; sb.push_back(c);
                  c = nw(); c.Write = 1; sb.push_back(c);
               end
            end
         end
         5'd19: begin
            c = nw(); c.Gra = 1; c.Rout = 1; c.CON_in = 1; sb.push_back(c);
            c = nw(); c.PC_out = 1; c.Y_in = 1; sb.push_back(c);
            c = nw(); c.C_out = 1; c.Z_in = 1; c.alu = 5'b00011; sb.push_back(c);
            c = nw(); c.Zlow_out = 1; c.PC_in = con; sb.push_back(c);
         end
         5'd20: begin c = nw(); c.Gra = 1; c.Rout = 1; c.PC_in = 1; sb.push_back(c); end
         5'd21: begin
            c = nw(); c.PC_out = 1; c.rx = 16'h8000; sb.push_back(c);
            c = nw(); c.Gra = 1; c.Rout = 1; c.PC_in = 1; sb.push_back(c);
         end
         5'd22: begin c = nw(); c.InPort_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c); end
         5'd23: begin c = nw(); c.Gra = 1; c.Rout = 1; c.OutPort_in = 1; sb.push_back(c); end
         5'd24: begin c = nw(); c.HI_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c); end
         5'd25: begin c = nw(); c.LO_out = 1; c.Gra = 1; c.Rin = 1; sb.push_back(c); end
         5'd27: begin
            sb.push_back(nw());
            repeat (10) sb.push_back('0);
         end
         default: sb.push_back(nw());
      endcase
   endtask

   task automatic drain(input string name, input int n);
      cw_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("%s step%0d", name, i), 64'(act), 64'(e));
      end
   endtask

   task automatic run_instr(input string name, input logic [31:0] ir, input logic con);
      next_instr = ir;
      CON_out    = con;
      push_seq(ir[31:27], con);
      drain(name, sb.size());
   endtask

   // Pulse clr low between a falling edge and the next rising edge.
   task automatic clr_pulse(input string name);
      #2 clr = 1'b0;
      #1 chk({name, " clr async"}, 64'(act), 64'(0));
      #1 clr = 1'b1;
   endtask

   initial begin
      #3 chk("reset outputs", 64'(act), 64'(0));
      @(negedge clk);
      chk("reset held", 64'(act), 64'(0));
      clr = 1'b1;
      run_instr("jr",    32'hA1000000, 1'b0);
      run_instr("add",   32'h1A920000, 1'b0);
      run_instr("br c0", 32'h99000005, 1'b0);
      run_instr("br c1", 32'h99000005, 1'b1);
      run_instr("and",   32'h2A920000, 1'b0);
      run_instr("addi",  32'h61100007, 1'b0);
      run_instr("neg",   32'h89100000, 1'b0);
      run_instr("mul",   32'h79100000, 1'b0);
      run_instr("div",   32'h81100000, 1'b0);
      run_instr("ld",    32'h00800010, 1'b0);
      run_instr("ldi",   32'h08800010, 1'b0);
      run_instr("st",    32'h10800010, 1'b0);
      run_instr("jal",   32'hA9000000, 1'b0);
      run_instr("in",    32'hB1000000, 1'b0);
      run_instr("out",   32'hB9000000, 1'b0);
      run_instr("mfhi",  32'hC1000000, 1'b0);
      run_instr("mflo",  32'hC9000000, 1'b0);
      run_instr("nop",   32'hD0000000, 1'b0);
      run_instr("undef", 32'hE0000000, 1'b0);
      // Abort an ld during T5, then restart cleanly.
      next_instr = 32'h00800010;
      push_seq(5'd0, 1'b0);
      drain("ld abort", 6);
      sb.delete();
      clr_pulse("ld T5");
      run_instr("after abort", 32'hB9000000, 1'b0);
      run_instr("halt", 32'hD8000000, 1'b0);
      clr_pulse("halt");
      run_instr("after halt", 32'hA1000000, 1'b0);
`ifdef CU_MEM_WAIT_EN
      next_instr = 32'hA1000000;
      push_seq(5'd20, 1'b0);
      repeat (3) sb.insert(1, sb[1]);
      mem_rdy = 1'b0;
      drain("wait T1", 5);
      mem_rdy = 1'b1;
      drain("wait rest", sb.size());
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
